regfile_bank: RTL and testbench
===============================

REGFILE_BANK -- requirements
Module: regfile_bank

Interface
REQ-001 Parameter DATA_W, default 64, register width in bits.
REQ-002 Parameter NUM_REGS, default 32, register count (2..32).
REQ-003 Parameter ADDR_W, default 5, address width; 2**ADDR_W >= NUM_REGS.
REQ-004 Parameter INIT_MODE, default 1, clear-sweep value: 0 = all zeros, 1 = register index zero-extended to DATA_W.
REQ-005 Parameter ZERO_REG, default 1, 1 = register 0 hardwired to zero.
REQ-006 The block SHALL use one clock and a synchronous, active-high reset, with ports as follows.
REQ-007 clk  input  1  rising-edge clock; all state changes on posedge clk.
REQ-008 reset  input  1  synchronous active-high reset; starts the clear sweep.
REQ-009 we  input  1  write enable.
REQ-010 waddr  input  ADDR_W  write address.
REQ-011 wdata  input  DATA_W  write data.
REQ-012 raddr1, raddr2  input  ADDR_W each  read addresses, ports 1 and 2.
REQ-013 rdata1, rdata2  output  DATA_W each  registered read data.
REQ-014 busy  output  1  high while the clear sweep runs.
REQ-015 wr_drop  output  1  registered one-cycle pulse: last cycle's write was discarded.

Function
REQ-016 FSM states: CLEAR, READY; sweep counter clr_idx of ADDR_W bits.
REQ-017 reset=1 at a posedge: state becomes CLEAR, clr_idx becomes 0; this holds in any state, including mid-sweep, which restarts from 0.
REQ-018 In CLEAR, each cycle writes the INIT_MODE value of clr_idx to register clr_idx, then increments clr_idx.
REQ-019 When clr_idx = NUM_REGS-1 is written, the next state is READY; a sweep takes NUM_REGS cycles after reset deasserts.
REQ-020 busy = 1 exactly while the state is CLEAR.
REQ-021 In CLEAR, external writes are discarded, and rdata1/rdata2 load 0.
REQ-022 In READY, with we=1 and waddr < NUM_REGS, wdata is stored at waddr at the posedge, unless ZERO_REG=1 and waddr=0.
REQ-023 In READY, rdataN loads the content of raddrN at each posedge; read latency is 1 cycle.
REQ-024 Write-through bypass: if we=1, the write is accepted, and waddr = raddrN in the same cycle, rdataN loads wdata, not the old content.
REQ-025 Reads of raddrN >= NUM_REGS return 0.
REQ-026 With ZERO_REG=1, reads of address 0 return 0 regardless of bypass or the INIT_MODE value.
REQ-027 wr_drop = 1 in the cycle after any of these cycles: we=1 during CLEAR; we=1 with waddr >= NUM_REGS; we=1 with waddr=0 when ZERO_REG=1. Otherwise wr_drop = 0.
REQ-028 Both read ports are independent and may address the same register in one cycle; both then return identical data.
REQ-029 Storage content is unchanged in any cycle with no accepted write and no sweep step.

Reset
REQ-030 In the cycle after reset=1: rdata1 = 0, rdata2 = 0, wr_drop = 0, busy = 1, state = CLEAR, clr_idx = 0.
REQ-031 No storage content is guaranteed before the first sweep completes; all register values are defined only after busy falls.
REQ-032 Reset asserted for multiple cycles holds clr_idx at 0, with busy = 1 throughout.

Verification
REQ-033 Defaults: pulse reset 1 cycle, hold we=0 -> busy = 1 for 32 cycles, then 0; a read of raddr1=17 returns 64'd17, and raddr2=0 returns 0.
REQ-034 In READY: we=1, waddr=5, wdata=64'hDEAD_BEEF, raddr1=5 in the same cycle -> rdata1 = 64'hDEAD_BEEF next cycle (bypass); the following read of address 5 returns the same value.
REQ-035 In READY: write 64'hFFFF to address 0 -> wr_drop = 1 next cycle; a read of address 0 returns 0. Write to address 31 with NUM_REGS=20, ADDR_W=5 -> wr_drop = 1; a read of address 31 returns 0.
REQ-036 Assert reset at sweep cycle 10, deassert next cycle -> busy stays high for 32 further cycles; register 9 holds 64'd9, not any earlier written value.
REQ-037 we=1, waddr=3, wdata=64'h55 during CLEAR -> wr_drop pulses; after READY, register 3 reads 64'd3.
REQ-038 DATA_W=32, NUM_REGS=8, ADDR_W=3, INIT_MODE=0 -> sweep lasts 8 cycles; all registers read 0; a write/read of 32'hA5A5_A5A5 at address 7 passes.

Source files
------------

// File: rtl/regfile_bank.sv
// Two-read/one-write register bank with a post-reset clear sweep.
// Reads are registered, bypass same-cycle writes, and report dropped writes.
module regfile_bank #(
  parameter int DATA_W    = 64,
  parameter int NUM_REGS  = 32,
  parameter int ADDR_W    = 5,
  parameter int INIT_MODE = 1,
  parameter int ZERO_REG  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic              busy,
  output logic              wr_drop
);

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_e;

  // One extra bit so NUM_REGS == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]   NREGS    = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS-1);

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < NREGS;
  endfunction

  function automatic logic zero_hit(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  state_e                   state_q, state_d;
  logic [ADDR_W-1:0]        clr_idx_q, clr_idx_d;
  logic [DATA_W-1:0]        mem_q [NUM_REGS];
  logic [DATA_W-1:0]        mem_d [NUM_REGS];
  logic [1:0][DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0][ADDR_W-1:0]   raddr;
  logic                     wr_drop_q, wr_drop_d;
  logic                     wr_ok;
  logic [DATA_W-1:0]        init_val;

  assign raddr = {raddr2, raddr1};

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    if (state_q == CLEAR) begin
      clr_idx_d = clr_idx_q + 1'b1;
      if (clr_idx_q == LAST_IDX) state_d = READY;
    end
  end

  // FSM outputs
  always_comb begin
    busy = (state_q == CLEAR);
  end

  always_comb begin
    init_val = (INIT_MODE != 0) ? DATA_W'(clr_idx_q) : '0;
    wr_ok    = !reset && (state_q == READY) && we && in_range(waddr) && !zero_hit(waddr);

    mem_d = mem_q;
    if (!reset && state_q == CLEAR) mem_d[clr_idx_q] = init_val;
    else if (wr_ok)                 mem_d[waddr]     = wdata;

    wr_drop_d = we && ((state_q == CLEAR) || !in_range(waddr) || zero_hit(waddr));

    for (int p = 0; p < 2; p++) begin
      rdata_d[p] = '0;
      if (state_q == READY && in_range(raddr[p]) && !zero_hit(raddr[p]))
        rdata_d[p] = (wr_ok && waddr == raddr[p]) ? wdata : mem_q[raddr[p]];
    end
  end

  // Storage has no reset; the sweep defines its contents.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q   <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      rdata_q   <= rdata_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  assign rdata1  = rdata_q[0];
  assign rdata2  = rdata_q[1];
  assign wr_drop = wr_drop_q;

endmodule

// File: tb/tb_regfile_bank.sv
// Directed bench for regfile_bank: default, 20-register and 32-bit/8-register zero-init configs.
module tb_regfile_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // u0 (defaults) and u1 (NUM_REGS=20) share stimulus
  logic        rst, we;
  logic [4:0]  waddr, raddr1, raddr2;
  logic [63:0] wdata;
  logic [63:0] rd1_0, rd2_0, rd1_1, rd2_1;
  logic        busy0, busy1, drop0, drop1;

  // u2: DATA_W=32, NUM_REGS=8, ADDR_W=3, INIT_MODE=0
  logic        rst2, we2;
  logic [2:0]  waddr2, raddr1_2, raddr2_2;
  logic [31:0] wdata2, rd1_2, rd2_2;
  logic        busy2, drop2;

  int n_chk  = 0;
  int n_fail = 0;
  int c0, c1, c2;

  regfile_bank u0 (
    .clk(clk), .reset(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1_0), .rdata2(rd2_0),
    .busy(busy0), .wr_drop(drop0));

  regfile_bank #(.NUM_REGS(20)) u1 (
    .clk(clk), .reset(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1_1), .rdata2(rd2_1),
    .busy(busy1), .wr_drop(drop1));

  regfile_bank #(.DATA_W(32), .NUM_REGS(8), .ADDR_W(3), .INIT_MODE(0)) u2 (
    .clk(clk), .reset(rst2), .we(we2), .waddr(waddr2), .wdata(wdata2),
    .raddr1(raddr1_2), .raddr2(raddr2_2), .rdata1(rd1_2), .rdata2(rd2_2),
    .busy(busy2), .wr_drop(drop2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
    rst2 = 1'b1; we2 = 1'b0; waddr2 = '0; wdata2 = '0; raddr1_2 = '0; raddr2_2 = '0;

    // Multi-cycle reset keeps the sweep parked
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rst_busy_%0d", i), 64'(busy0), 64'd1);
    end
    chk("rst_rdata1", rd1_0, 64'd0);
    chk("rst_rdata2", rd2_0, 64'd0);
    chk("rst_wr_drop", 64'(drop0), 64'd0);
    rst = 1'b0;

    c0 = 0; c1 = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy0) c0++;
      if (busy1) c1++;
      tick();
    end
    chk("sweep_len_32", 64'(c0), 64'd32);
    chk("sweep_len_20", 64'(c1), 64'd20);

    raddr1 = 5'd17; raddr2 = 5'd0; tick();
    chk("init_r17", rd1_0, 64'd17);
    chk("init_r0", rd2_0, 64'd0);
    chk("u1_init_r17", rd1_1, 64'd17);

    raddr1 = 5'd31; raddr2 = 5'd19; tick();
    chk("init_r31", rd1_0, 64'd31);
    chk("u1_oor_r31", rd1_1, 64'd0);
    chk("u1_init_r19", rd2_1, 64'd19);

    // Same-cycle bypass
    we = 1'b1; waddr = 5'd5; wdata = 64'hDEAD_BEEF; raddr1 = 5'd5; raddr2 = 5'd6; tick();
    chk("bypass_r5", rd1_0, 64'hDEAD_BEEF);
    chk("bypass_other_r6", rd2_0, 64'd6);
    chk("bypass_no_drop", 64'(drop0), 64'd0);
    we = 1'b0; raddr2 = 5'd5; tick();
    chk("stored_r5_p1", rd1_0, 64'hDEAD_BEEF);
    chk("stored_r5_p2", rd2_0, 64'hDEAD_BEEF);

    // Register 0 is hardwired, bypass included
    we = 1'b1; waddr = 5'd0; wdata = 64'hFFFF; raddr1 = 5'd0; raddr2 = 5'd0; tick();
    chk("zero_drop", 64'(drop0), 64'd1);
    chk("zero_bypass_r0", rd1_0, 64'd0);
    we = 1'b0; tick();
    chk("zero_drop_pulse_end", 64'(drop0), 64'd0);
    chk("zero_r0", rd2_0, 64'd0);

    // Address 31: valid in u0, out of range in u1
    we = 1'b1; waddr = 5'd31; wdata = 64'h1234; raddr1 = 5'd31; tick();
    chk("w31_u0_no_drop", 64'(drop0), 64'd0);
    chk("w31_u1_drop", 64'(drop1), 64'd1);
    chk("w31_u0_bypass", rd1_0, 64'h1234);
    chk("w31_u1_read", rd1_1, 64'd0);
    we = 1'b0; tick();
    chk("w31_u0_stored", rd1_0, 64'h1234);
    chk("w31_u1_read2", rd1_1, 64'd0);
    chk("w31_u1_drop_end", 64'(drop1), 64'd0);

    we = 1'b1; waddr = 5'd9; wdata = 64'h99; tick();
    we = 1'b0;

    // Restart sweep, write during CLEAR, then reset again at sweep cycle 10
    rst = 1'b1; tick();
    rst = 1'b0; we = 1'b1; waddr = 5'd3; wdata = 64'h55; raddr1 = 5'd17; tick();
    chk("clear_drop", 64'(drop0), 64'd1);
    chk("clear_rdata0", rd1_0, 64'd0);
    chk("clear_busy", 64'(busy0), 64'd1);
    we = 1'b0; tick();
    chk("clear_drop_end", 64'(drop0), 64'd0);
    for (int i = 0; i < 8; i++) tick();
    rst = 1'b1; tick();
    chk("midsweep_rst_busy", 64'(busy0), 64'd1);
    rst = 1'b0;
    c0 = 0; c1 = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy0) c0++;
      if (busy1) c1++;
      tick();
    end
    chk("restart_len_32", 64'(c0), 64'd32);
    chk("restart_len_20", 64'(c1), 64'd20);
    raddr1 = 5'd9; raddr2 = 5'd3; tick();
    chk("restart_r9", rd1_0, 64'd9);
    chk("restart_r3", rd2_0, 64'd3);
    raddr1 = 5'd5; raddr2 = 5'd31; tick();
    chk("restart_r5", rd1_0, 64'd5);
    chk("restart_r31", rd2_0, 64'd31);

    // Narrow, zero-init configuration
    tick();
    rst2 = 1'b0; we2 = 1'b1; waddr2 = 3'd3; wdata2 = 32'h55;
    c2 = busy2 ? 1 : 0;
    tick();
    chk("u2_clear_drop", 64'(drop2), 64'd1);
    we2 = 1'b0;
    for (int i = 0; i < 19; i++) begin
      if (busy2) c2++;
      tick();
    end
    chk("u2_sweep_len_8", 64'(c2), 64'd8);
    for (int i = 0; i < 8; i++) begin
      raddr1_2 = 3'(i); raddr2_2 = 3'(7 - i); tick();
      chk($sformatf("u2_zero_p1_r%0d", i), 64'(rd1_2), 64'd0);
      chk($sformatf("u2_zero_p2_r%0d", 7 - i), 64'(rd2_2), 64'd0);
    end
    we2 = 1'b1; waddr2 = 3'd7; wdata2 = 32'hA5A5_A5A5; raddr1_2 = 3'd0; tick();
    chk("u2_w7_no_drop", 64'(drop2), 64'd0);
    we2 = 1'b0; raddr1_2 = 3'd7; raddr2_2 = 3'd3; tick();
    chk("u2_r7", 64'(rd1_2), 64'hA5A5_A5A5);
    chk("u2_r3", 64'(rd2_2), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
